serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter DIGIT, default 8, bits processed per cycle; WIDTH is an integer multiple of DIGIT.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-005 SHALL have port io_in_valid, input, 1, operands valid.
REQ-006 SHALL have port io_in_ready, output, 1, block can accept operands.
REQ-007 SHALL have port io_a, input, WIDTH, minuend.
REQ-008 SHALL have port io_b, input, WIDTH, subtrahend.
REQ-009 SHALL have port io_bin, input, 1, borrow-in.
REQ-010 SHALL have port io_out_valid, output, 1, result valid.
REQ-011 SHALL have port io_out_ready, input, 1, consumer accepts result.
REQ-012 SHALL have port io_d, output, WIDTH, difference a - b - bin, modulo 2^WIDTH.
REQ-013 SHALL have port io_bout, output, 1, borrow-out; 1 iff a < b + bin (unsigned).

Function
REQ-014 SHALL implement FSM states IDLE, CALC, DONE.
REQ-015 SHALL assert io_in_ready only in IDLE; io_out_valid only in DONE.
REQ-016 SHALL, on io_in_valid && io_in_ready, capture io_a, io_b, io_bin, clear the digit counter, and enter CALC.
REQ-017 SHALL, in each CALC cycle, compute one DIGIT-bit slice, LSB slice first: {borrow, d_slice} = a_slice - b_slice - borrow, with borrow seeded by the captured bin.
REQ-018 SHALL advance the digit counter each CALC cycle and enter DONE after WIDTH/DIGIT cycles.
REQ-019 SHALL raise io_out_valid exactly WIDTH/DIGIT cycles after the accept edge (4 cycles at defaults).
REQ-020 SHALL hold io_d and io_bout stable in DONE until io_out_valid && io_out_ready, then return to IDLE.
REQ-021 SHALL ignore io_in_valid and operand changes outside IDLE; there is no back-to-back accept in the same cycle as the output handshake.
REQ-022 SHALL keep io_d at the last completed result in IDLE; io_d is undefined only as viewed during CALC.

Reset
REQ-023 SHALL, on reset low, asynchronously force state IDLE, counter 0, borrow 0, io_d 0, io_bout 0, io_out_valid 0, and io_in_ready 1 after release.
REQ-024 SHALL abandon any CALC or DONE operation on reset, producing no output handshake for it.

Configuration
REQ-025 SHALL, with macro SERIAL_SUB_OVERFLOW_EN defined, add output io_ovf (1 bit), equal to the signed overflow of a - b - bin, valid and held with io_d.
REQ-026 SHALL, without SERIAL_SUB_OVERFLOW_EN, omit io_ovf and its logic entirely; all other behaviour is identical.

Structure
REQ-027 SHALL place the WIDTH/DIGIT defaults and the state enum typedef in shared package serial_sub_pkg.
REQ-028 SHALL instantiate one sub-module digit_sub (DIGIT-bit combinational subtract with borrow in/out), reused every CALC cycle.

Verification
REQ-029 SHALL cover: a=10, b=3, bin=0 -> d=0x00000007, bout=0, out_valid 4 cycles after accept.
REQ-030 SHALL cover: a=0, b=1, bin=0 -> d=0xFFFFFFFF, bout=1.
REQ-031 SHALL cover: a=0x00000100, b=0x00000001 -> d=0x000000FF, bout=0, exercising borrow across a slice boundary; also a=5, b=5, bin=1 -> d=0xFFFFFFFF, bout=1.
REQ-032 SHALL cover: io_out_ready held low 3 cycles in DONE -> io_d and io_bout stable, io_in_ready=0, new io_in_valid ignored.
REQ-033 SHALL cover: reset asserted in the 2nd CALC cycle -> outputs 0 immediately, io_in_ready=1 after release, no io_out_valid.
REQ-034 SHALL cover, with SERIAL_SUB_OVERFLOW_EN: a=0x80000000, b=1 -> d=0x7FFFFFFF, ovf=1, bout=0.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the digit-serial subtractor: default widths and FSM states.
package serial_sub_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned DIGIT_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_digit_sub.sv
// One DIGIT-bit slice subtractor: {bout, d} = a - b - bin.
module digit_sub #(
  parameter int unsigned DIGIT = 8
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             bin_i,
  output logic [DIGIT-1:0] d_o,
  output logic             bout_o
);

  // Extend by one bit so the wrap-around of the subtraction lands in the borrow bit.
  always_comb begin
    {bout_o, d_o} = {1'b0, a_i} - {1'b0, b_i} - {{DIGIT{1'b0}}, bin_i};
  end

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: d = a - b - bin, DIGIT bits per cycle, LSB slice first.
// Valid/ready on both sides; result held in DONE until the consumer takes it.
// Optional signed-overflow output io_ovf when SERIAL_SUB_OVERFLOW_EN is defined.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DIGIT = DIGIT_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_a,
  input  logic [WIDTH-1:0] io_b,
  input  logic             io_bin,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_d,
`ifdef SERIAL_SUB_OVERFLOW_EN
  output logic             io_ovf,
`endif
  output logic             io_bout
);

  localparam int unsigned NDIG  = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             borrow_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] d_d;
  logic             bout_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [DIGIT-1:0] slice_d;
  logic             slice_bout;

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic a_msb_q;
  logic b_msb_q;
  logic ovf_q;
`endif

  // Single slice subtractor, fed the low digit of the shifting operand registers.
  digit_sub #(
    .DIGIT (DIGIT)
  ) u_digit_sub (
    .a_i    (a_q[DIGIT-1:0]),
    .b_i    (b_q[DIGIT-1:0]),
    .bin_i  (borrow_q),
    .d_o    (slice_d),
    .bout_o (slice_bout)
  );

  // Result register shifts right, new slice enters at the top; full after NDIG steps.
  always_comb begin
    d_d = d_q >> DIGIT;
    d_d[WIDTH-1 -: DIGIT] = slice_d;
  end

  // Control FSM with operand/result datapath; all outputs are registered here.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      borrow_q    <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      d_q         <= '0;
      bout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (io_in_valid && in_ready_q) begin
            a_q        <= io_a;
            b_q        <= io_b;
            borrow_q   <= io_bin;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= CALC;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb_q    <= io_a[WIDTH-1];
            b_msb_q    <= io_b[WIDTH-1];
`endif
          end
        end
        CALC: begin
          a_q      <= a_q >> DIGIT;
          b_q      <= b_q >> DIGIT;
          d_q      <= d_d;
          borrow_q <= slice_bout;
          if (cnt_q == LAST_CNT) begin
            cnt_q       <= '0;
            bout_q      <= slice_bout;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
`ifdef SERIAL_SUB_OVERFLOW_EN
            // Overflow when operand signs differ and the result sign differs from a.
            ovf_q       <= (a_msb_q ^ b_msb_q) & (slice_d[DIGIT-1] ^ a_msb_q);
`endif
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (io_out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign io_in_ready  = in_ready_q;
  assign io_out_valid = out_valid_q;
  assign io_d         = d_q;
  assign io_bout      = bout_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign io_ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at default WIDTH=32, DIGIT=8.
module tb_serial_subtractor;

  localparam int unsigned W   = 32;
  localparam int unsigned LAT = 4;

  logic          clock;
  logic          reset;
  logic          io_in_valid;
  logic          io_in_ready;
  logic [W-1:0]  io_a;
  logic [W-1:0]  io_b;
  logic          io_bin;
  logic          io_out_valid;
  logic          io_out_ready;
  logic [W-1:0]  io_d;
  logic          io_bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic          io_ovf;
`endif

  int n_checks;
  int n_fail;

  serial_subtractor dut (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_a         (io_a),
    .io_b         (io_b),
    .io_bin       (io_bin),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_d         (io_d),
`ifdef SERIAL_SUB_OVERFLOW_EN
    .io_ovf       (io_ovf),
`endif
    .io_bout      (io_bout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present operands at a negedge and hold valid through one rising edge (the accept edge).
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    @(negedge clock);
    chk("in_ready_idle", W'(io_in_ready), W'(1));
    io_a = a; io_b = b; io_bin = bin; io_in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    io_in_valid = 1'b0;
    io_a = '0; io_b = '0; io_bin = 1'b0;
    chk("in_ready_calc", W'(io_in_ready), W'(0));
  endtask

  // Count rising edges after the accept edge until out_valid appears (bounded).
  task automatic wait_done(output int cyc);
    cyc = 1;
    @(posedge clock);
    while (cyc < 20) begin
      @(negedge clock);
      if (io_out_valid) break;
      @(posedge clock);
      cyc++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    start_op(v.a, v.b, v.bin);
    wait_done(cyc);
    chk("latency", W'(cyc), W'(LAT));
    chk("d", io_d, v.d);
    chk("bout", W'(io_bout), W'(v.bout));
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("ovf", W'(io_ovf), W'(v.ovf));
`endif
    io_out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    io_out_ready = 1'b0;
    chk("out_valid_after_hs", W'(io_out_valid), W'(0));
    chk("in_ready_after_hs", W'(io_in_ready), W'(1));
    chk("d_held_idle", io_d, v.d);
  endtask

  initial begin
    int cyc;
    int seen;
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b0; io_in_valid = 1'b0; io_out_ready = 1'b0;
    io_a = '0; io_b = '0; io_bin = 1'b0;

    vecs[0] = '{32'd10,         32'd3,          1'b0, 32'h0000_0007, 1'b0, 1'b0};
    vecs[1] = '{32'd0,          32'd1,          1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[2] = '{32'h0000_0100,  32'h0000_0001,  1'b0, 32'h0000_00FF, 1'b0, 1'b0};
    vecs[3] = '{32'd5,          32'd5,          1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[4] = '{32'h1234_5678,  32'h1111_1111,  1'b0, 32'h0123_4567, 1'b0, 1'b0};
    vecs[5] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[6] = '{32'h8000_0000,  32'h0000_0001,  1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1};
    vecs[7] = '{32'h7FFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'h8000_0000, 1'b1, 1'b1};
    vecs[8] = '{32'h0001_0000,  32'h0000_0001,  1'b1, 32'h0000_FFFE, 1'b0, 1'b0};

    // Reset state
    #12;
    chk("rst_d", io_d, W'(0));
    chk("rst_bout", W'(io_bout), W'(0));
    chk("rst_out_valid", W'(io_out_valid), W'(0));
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_in_ready", W'(io_in_ready), W'(1));

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Consumer stalls 3 cycles in DONE while new operands are offered
    start_op(32'h0000_0100, 32'h0000_0001, 1'b0);
    wait_done(cyc);
    chk("stall_latency", W'(cyc), W'(LAT));
    io_in_valid = 1'b1; io_a = 32'hDEAD_BEEF; io_b = 32'h0; io_bin = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock);
      @(negedge clock);
      chk("stall_d", io_d, 32'h0000_00FF);
      chk("stall_bout", W'(io_bout), W'(0));
      chk("stall_in_ready", W'(io_in_ready), W'(0));
      chk("stall_out_valid", W'(io_out_valid), W'(1));
    end
    io_in_valid = 1'b0; io_a = '0; io_bin = 1'b0;
    io_out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    io_out_ready = 1'b0;
    chk("stall_release_in_ready", W'(io_in_ready), W'(1));
    chk("stall_release_d", io_d, 32'h0000_00FF);

    // Reset during the second CALC cycle abandons the operation
    start_op(32'd10, 32'd3, 1'b0);
    @(posedge clock);
    @(negedge clock);
    io_out_ready = 1'b1;
    reset = 1'b0;
    #1;
    chk("midrst_d", io_d, W'(0));
    chk("midrst_bout", W'(io_bout), W'(0));
    chk("midrst_out_valid", W'(io_out_valid), W'(0));
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_in_ready", W'(io_in_ready), W'(1));
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (io_out_valid) seen++;
    end
    chk("midrst_no_out_valid", W'(seen), W'(0));
    io_out_ready = 1'b0;

    // Machine still works after the abandoned operation
    run_vec(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
